// File: rtl/raytracer_pkg.sv
// Shared constants and enumerations for the voxel ray-traversal pipeline.
package raytracer_pkg;

  localparam int COORD_W    = 6;
  localparam int MAX_VAL    = 31;
  localparam int OCC_ADDR_W = 15;

  typedef enum logic [1:0] {
    ST_HIT   = 2'd0,
    ST_OOB   = 2'd1,
    ST_LIMIT = 2'd2,
    ST_ABORT = 2'd3
  } trav_status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_QUERY,
    S_STEP,
    S_DONE
  } trav_state_t;

endpackage

// File: rtl/bounds_check.sv
// Flags a voxel coordinate triple that lies outside 0..MAX_VAL on any axis.
module bounds_check #(
  parameter int COORD_W = 6,
  parameter int MAX_VAL = 31
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] z,
  output logic               out_of_bounds
);

  assign out_of_bounds = (x > COORD_W'(MAX_VAL)) ||
                         (y > COORD_W'(MAX_VAL)) ||
                         (z > COORD_W'(MAX_VAL));

endmodule

// File: rtl/dda_axis_sel.sv
// Picks the axis with the smallest tMax as a one-hot {z,y,x}; ties favour x, then y.
module dda_axis_sel #(
  parameter int T_W = 16
) (
  input  logic [T_W-1:0] tmax_x,
  input  logic [T_W-1:0] tmax_y,
  input  logic [T_W-1:0] tmax_z,
  output logic [2:0]     axis
);

  always_comb begin
    axis = 3'b100;
    if ((tmax_x <= tmax_y) && (tmax_x <= tmax_z)) begin
      axis = 3'b001;
    end else if (tmax_y <= tmax_z) begin
      axis = 3'b010;
    end
  end

endmodule

// File: rtl/dda_traverse_ctrl.sv
// Sequencer for one 3D DDA ray walk: bounds check -> occupancy query -> axis step,
// until hit, out-of-bounds, step limit or abort.
module dda_traverse_ctrl #(
  parameter int COORD_W   = raytracer_pkg::COORD_W,
  parameter int MAX_VAL   = raytracer_pkg::MAX_VAL,
  parameter int T_W       = 16,
  parameter int MAX_STEPS = 96,
  parameter int CNT_W     = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  output logic                                 ready,
  input  logic                                 abort,
  input  logic [COORD_W-1:0]                   ix0,
  input  logic [COORD_W-1:0]                   iy0,
  input  logic [COORD_W-1:0]                   iz0,
  input  logic [2:0]                           step_sgn,
  input  logic [T_W-1:0]                       tmax0_x,
  input  logic [T_W-1:0]                       tmax0_y,
  input  logic [T_W-1:0]                       tmax0_z,
  input  logic [T_W-1:0]                       tdelta_x,
  input  logic [T_W-1:0]                       tdelta_y,
  input  logic [T_W-1:0]                       tdelta_z,
  output logic                                 occ_req,
  output logic [raytracer_pkg::OCC_ADDR_W-1:0] occ_addr,
  input  logic                                 occ_valid,
  input  logic                                 occ_hit,
  output logic                                 busy,
  output logic                                 done,
  output logic [1:0]                           status,
  output logic [COORD_W-1:0]                   hit_x,
  output logic [COORD_W-1:0]                   hit_y,
  output logic [COORD_W-1:0]                   hit_z,
  output logic [CNT_W-1:0]                     step_cnt
);

  import raytracer_pkg::*;

  trav_state_t        state_q, state_d;
  logic [COORD_W-1:0] ix_q, ix_d, iy_q, iy_d, iz_q, iz_d;
  logic [2:0]         sgn_q, sgn_d;
  logic [T_W-1:0]     tmax_x_q, tmax_x_d, tmax_y_q, tmax_y_d, tmax_z_q, tmax_z_d;
  logic [T_W-1:0]     tdelta_x_q, tdelta_x_d, tdelta_y_q, tdelta_y_d, tdelta_z_q, tdelta_z_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  trav_status_t       status_q, status_d;
  logic [COORD_W-1:0] hit_x_q, hit_x_d, hit_y_q, hit_y_d, hit_z_q, hit_z_d;

  logic               oob;
  logic [2:0]         axis;
  logic               term;
  trav_status_t       term_status;

  function automatic logic [T_W-1:0] sat_add(input logic [T_W-1:0] a, input logic [T_W-1:0] b);
    logic [T_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[T_W] ? {T_W{1'b1}} : sum[T_W-1:0];
  endfunction

  // Wraps modulo 2**COORD_W on purpose: 0-1 and 31+1 both land in the guard range.
  function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c, input logic up);
    return up ? (c + COORD_W'(1)) : (c - COORD_W'(1));
  endfunction

  bounds_check #(
    .COORD_W (COORD_W),
    .MAX_VAL (MAX_VAL)
  ) u_bounds (
    .x             (ix_q),
    .y             (iy_q),
    .z             (iz_q),
    .out_of_bounds (oob)
  );

  dda_axis_sel #(
    .T_W (T_W)
  ) u_axis_sel (
    .tmax_x (tmax_x_q),
    .tmax_y (tmax_y_q),
    .tmax_z (tmax_z_q),
    .axis   (axis)
  );

  always_comb begin
    state_d     = state_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    iz_d        = iz_q;
    sgn_d       = sgn_q;
    tmax_x_d    = tmax_x_q;
    tmax_y_d    = tmax_y_q;
    tmax_z_d    = tmax_z_q;
    tdelta_x_d  = tdelta_x_q;
    tdelta_y_d  = tdelta_y_q;
    tdelta_z_d  = tdelta_z_q;
    cnt_d       = cnt_q;
    status_d    = status_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    hit_z_d     = hit_z_q;
    term        = 1'b0;
    term_status = ST_HIT;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ix_d       = ix0;
          iy_d       = iy0;
          iz_d       = iz0;
          sgn_d      = step_sgn;
          tmax_x_d   = tmax0_x;
          tmax_y_d   = tmax0_y;
          tmax_z_d   = tmax0_z;
          tdelta_x_d = tdelta_x;
          tdelta_y_d = tdelta_y;
          tdelta_z_d = tdelta_z;
          cnt_d      = '0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          term        = 1'b1;
          term_status = ST_ABORT;
        end else if (oob) begin
          term        = 1'b1;
          term_status = ST_OOB;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_QUERY;
        end
      end
      S_QUERY: begin
        // Abort outranks a coincident memory response, which is then dropped.
        if (abort) begin
          term        = 1'b1;
          term_status = ST_ABORT;
        end else if (occ_valid) begin
          if (occ_hit) begin
            term        = 1'b1;
            term_status = ST_HIT;
          end else if (cnt_q == CNT_W'(MAX_STEPS)) begin
            term        = 1'b1;
            term_status = ST_LIMIT;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (abort) begin
          term        = 1'b1;
          term_status = ST_ABORT;
        end else begin
          if (axis[0]) begin
            ix_d     = step_coord(ix_q, sgn_q[0]);
            tmax_x_d = sat_add(tmax_x_q, tdelta_x_q);
          end else if (axis[1]) begin
            iy_d     = step_coord(iy_q, sgn_q[1]);
            tmax_y_d = sat_add(tmax_y_q, tdelta_y_q);
          end else begin
            iz_d     = step_coord(iz_q, sgn_q[2]);
            tmax_z_d = sat_add(tmax_z_q, tdelta_z_q);
          end
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (term) begin
      state_d  = S_DONE;
      status_d = term_status;
      hit_x_d  = ix_q;
      hit_y_d  = iy_q;
      hit_z_d  = iz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ix_q       <= '0;
      iy_q       <= '0;
      iz_q       <= '0;
      sgn_q      <= '0;
      tmax_x_q   <= '0;
      tmax_y_q   <= '0;
      tmax_z_q   <= '0;
      tdelta_x_q <= '0;
      tdelta_y_q <= '0;
      tdelta_z_q <= '0;
      cnt_q      <= '0;
      status_q   <= ST_HIT;
      hit_x_q    <= '0;
      hit_y_q    <= '0;
      hit_z_q    <= '0;
    end else begin
      state_q    <= state_d;
      ix_q       <= ix_d;
      iy_q       <= iy_d;
      iz_q       <= iz_d;
      sgn_q      <= sgn_d;
      tmax_x_q   <= tmax_x_d;
      tmax_y_q   <= tmax_y_d;
      tmax_z_q   <= tmax_z_d;
      tdelta_x_q <= tdelta_x_d;
      tdelta_y_q <= tdelta_y_d;
      tdelta_z_q <= tdelta_z_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      hit_x_q    <= hit_x_d;
      hit_y_q    <= hit_y_d;
      hit_z_q    <= hit_z_d;
    end
  end

  // Coordinates never move while in QUERY, so the address is stable for the whole request.
  assign occ_addr = {iz_q[4:0], iy_q[4:0], ix_q[4:0]};
  assign occ_req  = (state_q == S_QUERY);
  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_CHECK) || (state_q == S_QUERY) || (state_q == S_STEP);
  assign done     = (state_q == S_DONE);
  assign status   = status_q;
  assign hit_x    = hit_x_q;
  assign hit_y    = hit_y_q;
  assign hit_z    = hit_z_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_dda_traverse_ctrl.sv
// Scoreboard bench for dda_traverse_ctrl: a behavioural ray-walk model queues expected
// query addresses and results; a negedge monitor compares them as the DUT presents them.
module tb_dda_traverse_ctrl;

  import raytracer_pkg::*;

  localparam int CW   = 6;
  localparam int TW   = 16;
  localparam int CNTW = 7;
  // A monotonic walk inside 32^3 can issue at most 94 queries, so a limit of 96 is
  // unreachable; a smaller limit makes LIMIT observable.
  localparam int TB_MAX_STEPS = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] ix0 = '0, iy0 = '0, iz0 = '0;
  logic [2:0]    step_sgn = '0;
  logic [TW-1:0] tmax0_x = '0, tmax0_y = '0, tmax0_z = '0;
  logic [TW-1:0] tdelta_x = '0, tdelta_y = '0, tdelta_z = '0;
  logic          occ_valid = 1'b0;
  logic          occ_hit = 1'b0;
  logic          occ_req, ready, busy, done;
  logic [14:0]   occ_addr;
  logic [1:0]    status;
  logic [CW-1:0] hit_x, hit_y, hit_z;
  logic [CNTW-1:0] step_cnt;

  typedef struct {
    int st;
    int hx;
    int hy;
    int hz;
    int cnt;
  } result_t;

  result_t     exp_res_q[$];
  int          exp_addr_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned occ_seed = 0;
  int          occ_density = 0;
  int          forced_addr = -1;
  int          resp_lat = 2;
  int          resp_abort_q = 0;
  int          resp_qidx = 0;
  int          resp_cnt = 0;
  bit          mon_en = 1'b1;
  logic        prev_req = 1'b0;
  logic        prev_done = 1'b0;
  int          held_addr = 0;
  int          query_count = 0;

  dda_traverse_ctrl #(
    .COORD_W   (CW),
    .MAX_VAL   (31),
    .T_W       (TW),
    .MAX_STEPS (TB_MAX_STEPS),
    .CNT_W     (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .abort     (abort),
    .ix0       (ix0),
    .iy0       (iy0),
    .iz0       (iz0),
    .step_sgn  (step_sgn),
    .tmax0_x   (tmax0_x),
    .tmax0_y   (tmax0_y),
    .tmax0_z   (tmax0_z),
    .tdelta_x  (tdelta_x),
    .tdelta_y  (tdelta_y),
    .tdelta_z  (tdelta_z),
    .occ_req   (occ_req),
    .occ_addr  (occ_addr),
    .occ_valid (occ_valid),
    .occ_hit   (occ_hit),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
    .hit_z     (hit_z),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic reportMissing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: DUT produced an output with nothing expected at %0t", name, $time);
  endtask

  // Pseudo-random voxel occupancy, reproducible per ray from occ_seed.
  function automatic bit occupied(input int addr);
    int unsigned h;
    if (addr == forced_addr) return 1'b1;
    h = (addr * 32'h9E3779B1) ^ occ_seed;
    h = h ^ (h >> 15);
    return int'(h % 64) < occ_density;
  endfunction

  task automatic setOcc(input int density, input int faddr);
    occ_density = density;
    forced_addr = faddr;
    occ_seed    = $urandom;
  endtask

  // Reference ray walk: plain integer arithmetic over the traversal rules.
  task automatic modelRay(input int x, input int y, input int z, input logic [2:0] sgn,
                          input int tx, input int ty, input int tz,
                          input int dx, input int dy, input int dz,
                          input int abort_at, output result_t r);
    int c[3];
    int t[3];
    int d[3];
    int n;
    int a;
    int addr;
    bit fin;
    c = '{x, y, z};
    t = '{tx, ty, tz};
    d = '{dx, dy, dz};
    n = 0;
    fin = 1'b0;
    r = '{default: 0};
    while (!fin) begin
      if (c[0] > 31 || c[1] > 31 || c[2] > 31) begin
        r.st = int'(ST_OOB);
        fin  = 1'b1;
      end else begin
        n++;
        addr = c[2] * 1024 + c[1] * 32 + c[0];
        exp_addr_q.push_back(addr);
        if (n == abort_at) begin
          r.st = int'(ST_ABORT);
          fin  = 1'b1;
        end else if (occupied(addr)) begin
          r.st = int'(ST_HIT);
          fin  = 1'b1;
        end else if (n == TB_MAX_STEPS) begin
          r.st = int'(ST_LIMIT);
          fin  = 1'b1;
        end else begin
          a = (t[0] <= t[1] && t[0] <= t[2]) ? 0 : ((t[1] <= t[2]) ? 1 : 2);
          c[a] = (c[a] + (sgn[a] ? 1 : 63)) % 64;
          t[a] = (t[a] + d[a] > 65535) ? 65535 : t[a] + d[a];
        end
      end
    end
    r.hx  = c[0];
    r.hy  = c[1];
    r.hz  = c[2];
    r.cnt = n;
    exp_res_q.push_back(r);
  endtask

  task automatic scrambleInputs();
    ix0      = CW'($urandom);
    iy0      = CW'($urandom);
    iz0      = CW'($urandom);
    step_sgn = 3'($urandom);
    tmax0_x  = TW'($urandom);
    tmax0_y  = TW'($urandom);
    tmax0_z  = TW'($urandom);
    tdelta_x = TW'($urandom);
    tdelta_y = TW'($urandom);
    tdelta_z = TW'($urandom);
  endtask

  task automatic applyStimulus(input int x, input int y, input int z, input logic [2:0] sgn,
                               input int tx, input int ty, input int tz,
                               input int dx, input int dy, input int dz,
                               input int abort_at, input int lat);
    result_t r;
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("ready_before_start", ready, 1);
    resp_lat     = lat;
    resp_abort_q = abort_at;
    resp_qidx    = 0;
    modelRay(x, y, z, sgn, tx, ty, tz, dx, dy, dz, abort_at, r);
    ix0      = CW'(x);
    iy0      = CW'(y);
    iz0      = CW'(z);
    step_sgn = sgn;
    tmax0_x  = TW'(tx);
    tmax0_y  = TW'(ty);
    tmax0_z  = TW'(tz);
    tdelta_x = TW'(dx);
    tdelta_y = TW'(dy);
    tdelta_z = TW'(dz);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scrambleInputs();
    k = 0;
    // Stray start pulses while busy must not disturb the walk.
    while (done !== 1'b1 && k < 1000) begin
      start = busy && ($urandom_range(0, 5) == 0);
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      checkOutput("done_timeout", done, 1);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_addr_q.delete();
      exp_res_q.delete();
    end else begin
      start = 1'b1;
      scrambleInputs();
      @(negedge clk);
      start = 1'b0;
      checkOutput("ready_after_done", ready, 1);
      checkOutput("busy_after_done_start", busy, 0);
      checkOutput("status_held", status, r.st);
      checkOutput("hit_x_held", hit_x, r.hx);
      checkOutput("hit_y_held", hit_y, r.hy);
      checkOutput("hit_z_held", hit_z, r.hz);
      checkOutput("step_cnt_held", step_cnt, r.cnt);
    end
  endtask

  task automatic resetMidQuery();
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    mon_en       = 1'b0;
    resp_lat     = 1000;
    resp_abort_q = 0;
    setOcc(0, -1);
    ix0      = CW'(10);
    iy0      = CW'(10);
    iz0      = CW'(10);
    step_sgn = 3'b111;
    tmax0_x  = TW'(3);
    tmax0_y  = TW'(4);
    tmax0_z  = TW'(5);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (occ_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("occ_req_before_reset", occ_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_occ_req", occ_req, 0);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_hit_x", hit_x, 0);
    checkOutput("rst_hit_y", hit_y, 0);
    checkOutput("rst_hit_z", hit_z, 0);
    checkOutput("rst_step_cnt", step_cnt, 0);
    checkOutput("rst_occ_addr", occ_addr, 0);
    rst      = 1'b0;
    resp_lat = 2;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  // Memory responder: answers each request after resp_lat cycles of occ_req,
  // optionally raising abort in the same cycle as the chosen response.
  always @(negedge clk) begin
    if (rst) begin
      occ_valid = 1'b0;
      abort     = 1'b0;
      resp_cnt  = 0;
    end else if (occ_valid) begin
      occ_valid = 1'b0;
      abort     = 1'b0;
      resp_cnt  = 0;
      occ_hit   = 1'($urandom_range(0, 1));
    end else if (occ_req) begin
      resp_cnt++;
      if (resp_cnt == 1) resp_qidx++;
      if (resp_cnt == resp_lat) begin
        occ_valid = 1'b1;
        occ_hit   = occupied(int'(occ_addr));
        if (resp_qidx == resp_abort_q) abort = 1'b1;
      end
    end else begin
      resp_cnt = 0;
      occ_hit  = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops expected query addresses and ray results as the DUT presents them.
  always @(negedge clk) begin
    result_t r;
    if (mon_en && !rst) begin
      if (occ_req && !prev_req) begin
        query_count++;
        if (exp_addr_q.size() == 0) reportMissing("unexpected_query");
        else checkOutput("occ_addr", occ_addr, exp_addr_q.pop_front());
        held_addr = int'(occ_addr);
      end else if (occ_req) begin
        checkOutput("occ_addr_stable", occ_addr, held_addr);
      end
      if (done) begin
        checkOutput("done_single_pulse", prev_done, 0);
        if (exp_res_q.size() == 0) begin
          reportMissing("unexpected_done");
        end else begin
          r = exp_res_q.pop_front();
          checkOutput("status", status, r.st);
          checkOutput("hit_x", hit_x, r.hx);
          checkOutput("hit_y", hit_y, r.hy);
          checkOutput("hit_z", hit_z, r.hz);
          checkOutput("step_cnt", step_cnt, r.cnt);
          checkOutput("queries_not_issued", exp_addr_q.size(), 0);
          exp_addr_q.delete();
        end
      end
    end
    prev_req  = occ_req;
    prev_done = done;
  end

  initial begin
    int qc0;
    int x, y, z;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_occ_req", occ_req, 0);
    checkOutput("reset_status", status, 0);
    checkOutput("reset_hit_x", hit_x, 0);
    checkOutput("reset_step_cnt", step_cnt, 0);
    checkOutput("reset_occ_addr", occ_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed: hit one step away");
    setOcc(0, 5 * 1024 + 5 * 32 + 6);
    applyStimulus(5, 5, 5, 3'b111, 10, 20, 30, 10, 10, 10, 0, 2);

    $display("[TB] directed: leaving the grid at 31+1 and 0-1");
    setOcc(0, -1);
    applyStimulus(31, 0, 0, 3'b001, 1, 9, 9, 4, 4, 4, 0, 2);
    applyStimulus(0, 0, 0, 3'b110, 1, 9, 9, 4, 4, 4, 0, 2);

    $display("[TB] directed: three-way tie, slow memory");
    applyStimulus(10, 10, 10, 3'b111, 7, 7, 7, 10, 10, 10, 0, 3);

    $display("[TB] directed: step limit and tMax saturation");
    applyStimulus(0, 0, 0, 3'b111, 0, 0, 0, 1, 1, 1, 0, 2);
    applyStimulus(10, 10, 10, 3'b111, 16'hFFF0, 16'hFFF8, 16'hFFFF, 16'h20, 16'h20, 16'h20, 0, 2);

    $display("[TB] directed: abort coinciding with a hit response, then reset mid-query");
    setOcc(0, 5 * 1024 + 5 * 32 + 6);
    applyStimulus(5, 5, 5, 3'b111, 10, 20, 30, 10, 10, 10, 2, 2);
    resetMidQuery();

    $display("[TB] directed: start voxel already outside the grid");
    setOcc(0, -1);
    qc0 = query_count;
    applyStimulus(40, 0, 0, 3'b111, 1, 2, 3, 1, 1, 1, 0, 2);
    checkOutput("oob_start_queries", query_count - qc0, 0);

    $display("[TB] randomized rays");
    for (int i = 0; i < 24; i++) begin
      setOcc($urandom_range(0, 6), -1);
      x = ($urandom_range(0, 7) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 31);
      y = $urandom_range(0, 31);
      z = $urandom_range(0, 31);
      applyStimulus(x, y, z, 3'($urandom),
                    $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
                    $urandom_range(1, 4096), $urandom_range(1, 4096), $urandom_range(1, 65535),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0,
                    $urandom_range(2, 4));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
